// File: rtl/gas_alarm_controller.sv
// gas_alarm_controller: qualifies gas detections, drives alarm, buzzer and fan, counts events
module gas_alarm_controller #(
    parameter int QUAL_CYCLES = 4,
    parameter int BEEP_HALF   = 8,
    parameter int VENT_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [2:0]       det,
    input  logic             ack,
    output logic             alarm,
    output logic [1:0]       gas_id,
    output logic             buzzer,
    output logic             fan,
    output logic [CNT_W-1:0] evt_cnt
);
    typedef enum logic [2:0] {IDLE, QUAL, ALARM, ACKED, VENT} state_t;

    localparam logic [7:0]  Q_LAST = 8'(QUAL_CYCLES - 1);
    localparam logic [7:0]  B_LAST = 8'(BEEP_HALF - 1);
    localparam logic [15:0] V_LAST = 16'(VENT_CYCLES - 1);

    state_t      state;
    logic [7:0]  qcnt;
    logic [7:0]  bcnt;
    logic [15:0] vcnt;
    logic [1:0]  prio;
    logic        det_any;
    logic        go_alarm;

    // highest-priority gas present and whether this edge enters ALARM from outside it
    always_comb begin
        prio     = det[2] ? 2'd3 : det[1] ? 2'd2 : det[0] ? 2'd1 : 2'd0;
        det_any  = |det;
        go_alarm = (state == IDLE  && det_any && QUAL_CYCLES == 1) ||
                   (state == QUAL  && det_any && qcnt == Q_LAST)   ||
                   (state == ACKED && prio > gas_id)               ||
                   (state == VENT  && det_any);
    end

    // state machine with all outputs registered alongside the state
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state   <= IDLE;
            qcnt    <= '0;
            bcnt    <= '0;
            vcnt    <= '0;
            alarm   <= 1'b0;
            gas_id  <= 2'd0;
            buzzer  <= 1'b0;
            fan     <= 1'b0;
            evt_cnt <= '0;
        end else if (go_alarm) begin
            state   <= ALARM;
            qcnt    <= '0;
            bcnt    <= '0;
            alarm   <= 1'b1;
            gas_id  <= prio;
            buzzer  <= 1'b1;
            fan     <= 1'b1;
            evt_cnt <= (evt_cnt == '1) ? evt_cnt : evt_cnt + CNT_W'(1);
        end else begin
            case (state)
                IDLE: begin
                    if (det_any) begin
                        state <= QUAL;
                        qcnt  <= 8'd1;
                    end
                end
                QUAL: begin
                    if (!det_any) begin
                        state <= IDLE;
                        qcnt  <= '0;
                    end else begin
                        qcnt <= qcnt + 8'd1;
                    end
                end
                ALARM: begin
                    if (prio > gas_id)
                        gas_id <= prio;
                    if (ack) begin
                        state  <= ACKED;
                        buzzer <= 1'b0;
                        bcnt   <= '0;
                    end else if (bcnt == B_LAST) begin
                        buzzer <= ~buzzer;
                        bcnt   <= '0;
                    end else begin
                        bcnt <= bcnt + 8'd1;
                    end
                end
                ACKED: begin
                    if (!det_any) begin
                        state <= VENT;
                        vcnt  <= V_LAST;
                        alarm <= 1'b0;
                    end
                end
                VENT: begin
                    if (vcnt == 16'd0) begin
                        state  <= IDLE;
                        fan    <= 1'b0;
                        gas_id <= 2'd0;
                    end else begin
                        vcnt <= vcnt - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
